// File: rtl/vga_fb_painter.sv
`timescale 1ns/1ps
// Cell-based frame buffer for a 640x480 VGA scan driver, with a rectangle-fill engine
// that writes one 4x4-pixel cell per clock independently of scan-out.
module vga_fb_painter #(
    parameter int COLS       = 160,
    parameter int ROWS       = 120,
    parameter int CELL_SHIFT = 2
) (
    input  logic        clk_25mHz,
    input  logic        rst_n,
    input  logic [8:0]  row,
    input  logic [9:0]  col,
    input  logic        rdn,
    output logic [11:0] Din,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_clear,
    input  logic [7:0]  cmd_x0,
    input  logic [7:0]  cmd_x1,
    input  logic [6:0]  cmd_y0,
    input  logic [6:0]  cmd_y1,
    input  logic [11:0] cmd_color,
    output logic        busy,
    output logic        done
);
    localparam int DEPTH = COLS * ROWS;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    logic [11:0] r_mem [0:DEPTH-1];

    state_t      r_state;
    logic        r_ready, r_busy, r_done;
    logic [7:0]  r_x, r_x0, r_x1;
    logic [6:0]  r_y, r_y1;
    logic [14:0] r_base;
    logic [11:0] r_color;
    logic [11:0] r_din;

    logic [7:0]  w_cx;
    logic [6:0]  w_cy;
    logic        w_rd_ok;
    logic [14:0] w_rd_addr;
    logic [7:0]  w_x1c, w_fx0, w_fx1;
    logic [6:0]  w_y1c, w_fy0, w_fy1;
    logic        w_empty, w_accept, w_last_x, w_last, w_we;
    logic [14:0] w_wr_addr;

    // Blanking addresses wrap past the frame, so they are gated rather than aliased.
    assign w_cx      = 8'(col >> CELL_SHIFT);
    assign w_cy      = 7'(row >> CELL_SHIFT);
    assign w_rd_ok   = !rdn && (col < 10'(COLS << CELL_SHIFT)) && (row < 9'(ROWS << CELL_SHIFT));
    assign w_rd_addr = w_rd_ok ? (15'(w_cy) * 15'(COLS) + 15'(w_cx)) : '0;

    assign w_x1c   = (cmd_x1 > 8'(COLS - 1)) ? 8'(COLS - 1) : cmd_x1;
    assign w_y1c   = (cmd_y1 > 7'(ROWS - 1)) ? 7'(ROWS - 1) : cmd_y1;
    assign w_fx0   = cmd_clear ? 8'd0 : cmd_x0;
    assign w_fy0   = cmd_clear ? 7'd0 : cmd_y0;
    assign w_fx1   = cmd_clear ? 8'(COLS - 1) : w_x1c;
    assign w_fy1   = cmd_clear ? 7'(ROWS - 1) : w_y1c;
    // An origin past the limit always exceeds the clamped far bound, so this covers it.
    assign w_empty = (w_fx0 > w_fx1) || (w_fy0 > w_fy1);

    assign w_accept  = cmd_valid && r_ready;
    assign w_last_x  = (r_x == r_x1);
    assign w_last    = w_last_x && (r_y == r_y1);
    assign w_we      = (r_state == S_FILL);
    assign w_wr_addr = r_base + 15'(r_x);

    assign Din       = r_din;
    assign cmd_ready = r_ready;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk_25mHz) begin
        if (w_we)
            r_mem[w_wr_addr] <= r_color;
    end

    // Non-blocking write above makes a same-cell read return the old value.
    always_ff @(posedge clk_25mHz or negedge rst_n) begin
        if (!rst_n)
            r_din <= '0;
        else
            r_din <= w_rd_ok ? r_mem[w_rd_addr] : 12'h000;
    end

    always_ff @(posedge clk_25mHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= '0;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y     <= '0;
            r_y1    <= '0;
            r_base  <= '0;
            r_color <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_x     <= w_fx0;
                        r_x0    <= w_fx0;
                        r_x1    <= w_fx1;
                        r_y     <= w_fy0;
                        r_y1    <= w_fy1;
                        r_base  <= 15'(w_fy0) * 15'(COLS);
                        r_color <= cmd_color;
                        r_ready <= 1'b0;
                        if (w_empty) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_FILL;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_last_x) begin
                        r_x    <= r_x0;
                        r_y    <= r_y + 7'd1;
                        r_base <= r_base + 15'(COLS);
                    end else begin
                        r_x <= r_x + 8'd1;
                    end
                end
                S_DONE: begin
                    // An empty command arrives here with done low and raises it one cycle later.
                    if (!r_done) begin
                        r_done <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_fb_painter.sv
`timescale 1ns/1ps
// Directed and randomized bench for vga_fb_painter against a cell-array reference model.
module tb_vga_fb_painter;
    localparam int COLS = 160;
    localparam int ROWS = 120;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [8:0]  row;
    logic [9:0]  col;
    logic        rdn;
    logic [11:0] Din;
    logic        cmd_valid, cmd_ready, cmd_clear;
    logic [7:0]  cmd_x0, cmd_x1;
    logic [6:0]  cmd_y0, cmd_y1;
    logic [11:0] cmd_color;
    logic        busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] model_mem [0:COLS*ROWS-1];

    always #20 clk = ~clk;

    vga_fb_painter #(.COLS(COLS), .ROWS(ROWS), .CELL_SHIFT(2)) dut (
        .clk_25mHz(clk), .rst_n(rst_n), .row(row), .col(col), .rdn(rdn), .Din(Din),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_clear(cmd_clear),
        .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
        .cmd_color(cmd_color), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: clamp the bounds and paint every covered cell; returns cells written.
    task automatic model_fill(input logic clr, input int x0, input int x1, input int y0,
                              input int y1, input logic [11:0] c, output int n);
        n = 0;
        if (clr) begin x0 = 0; y0 = 0; x1 = COLS - 1; y1 = ROWS - 1; end
        if (x1 > COLS - 1) x1 = COLS - 1;
        if (y1 > ROWS - 1) y1 = ROWS - 1;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++) begin
                model_mem[y*COLS + x] = c;
                n++;
            end
    endtask

    task automatic scan(input int r, input int c, input logic rd, output logic [11:0] d);
        @(negedge clk);
        row = 9'(r); col = 10'(c); rdn = rd;
        @(negedge clk);
        d = Din;
    endtask

    task automatic px_is(input string tag, input int r, input int c, input logic [11:0] exp);
        logic [11:0] d;
        scan(r, c, 1'b0, d);
        check(tag, 32'(d), 32'(exp));
    endtask

    task automatic px_model(input string tag, input int r, input int c);
        logic [11:0] d;
        scan(r, c, 1'b0, d);
        check(tag, 32'(d), 32'(model_mem[(r/4)*COLS + c/4]));
    endtask

    task automatic send(input string tag, input logic clr, input int x0, input int x1,
                        input int y0, input int y1, input logic [11:0] c);
        int n, cyc, bcyc, exp_cyc;
        model_fill(clr, x0, x1, y0, y1, c, n);
        exp_cyc = (n == 0) ? 1 : n;
        @(negedge clk);
        rdn = 1'b1;
        check({tag, "_ready_before"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_clear = clr; cmd_color = c;
        cmd_x0 = 8'(x0); cmd_x1 = 8'(x1); cmd_y0 = 7'(y0); cmd_y1 = 7'(y1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check({tag, "_ready_after_accept"}, 32'(cmd_ready), 32'd0);
        cyc = 0; bcyc = 0;
        while (!done && cyc < 20000) begin
            if (busy) bcyc++;
            @(negedge clk);
            cyc++;
        end
        check({tag, "_done_latency"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_busy_cycles"}, 32'(bcyc), 32'(n));
        @(negedge clk);
        check({tag, "_done_single"}, 32'(done), 32'd0);
        check({tag, "_ready_return"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int rx0, rx1, ry0, ry1;
        logic [11:0] d;

        rst_n = 1'b0; row = '0; col = '0; rdn = 1'b1;
        cmd_valid = 1'b0; cmd_clear = 1'b0; cmd_x0 = '0; cmd_x1 = '0;
        cmd_y0 = '0; cmd_y1 = '0; cmd_color = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_din", 32'(Din), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        send("clear_f00", 1'b1, 37, 3, 99, 2, 12'hF00);
        px_is("clr_origin", 0, 0, 12'hF00);
        px_is("clr_corner", 479, 639, 12'hF00);

        scan(0, 0, 1'b1, d);
        check("blank_rdn", 32'(d), 32'd0);
        scan(0, 10'h3F0, 1'b0, d);
        check("blank_col_wrap", 32'(d), 32'd0);
        scan(9'h1F0, 0, 1'b0, d);
        check("blank_row_wrap", 32'(d), 32'd0);

        send("clear_000", 1'b1, 0, 0, 0, 0, 12'h000);
        send("rect", 1'b0, 2, 4, 3, 5, 12'h0A5);
        px_is("rect_in", 12, 8, 12'h0A5);
        px_is("rect_left", 12, 7, 12'h000);
        px_is("rect_below", 24, 8, 12'h000);
        px_is("rect_far", 23, 19, 12'h0A5);

        send("clamp", 1'b0, 150, 255, 0, 0, 12'h3C7);
        px_is("clamp_first", 0, 600, 12'h3C7);
        px_is("clamp_last", 3, 639, 12'h3C7);
        px_is("clamp_before", 0, 599, 12'h000);
        px_is("clamp_next_row", 4, 620, 12'h000);

        send("empty", 1'b0, 5, 4, 0, 0, 12'hFFF);
        px_is("empty_nochange", 0, 20, 12'h000);
        send("empty_origin", 1'b0, 200, 255, 0, 3, 12'hFFF);

        for (int i = 0; i < 8; i++) begin
            rx0 = $urandom_range(0, 165);
            rx1 = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : rx0 + $urandom_range(0, 15);
            if (rx1 > 255) rx1 = 255;
            ry0 = $urandom_range(0, 125);
            ry1 = ry0 + $urandom_range(0, 12) - 1;
            if (ry1 > 127) ry1 = 127;
            if (ry1 < 0) ry1 = 0;
            send($sformatf("rand%0d", i), 1'b0, rx0, rx1, ry0, ry1, 12'($urandom));
            for (int k = 0; k < 12; k++)
                px_model($sformatf("rand%0d_px", i), $urandom_range(0, 479), $urandom_range(0, 639));
            if (rx0 < COLS && ry0 < ROWS)
                px_model($sformatf("rand%0d_origin", i), ry0*4 + 1, rx0*4 + 2);
        end

        // Abort a 50x2 fill after its 40th write edge.
        @(negedge clk);
        rdn = 1'b1;
        cmd_valid = 1'b1; cmd_clear = 1'b0; cmd_color = 12'hABC;
        cmd_x0 = 8'd10; cmd_x1 = 8'd59; cmd_y0 = 7'd20; cmd_y1 = 7'd21;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 40; k++) model_mem[(20 + k/50)*COLS + 10 + k%50] = 12'hABC;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        begin
            int seen = 0;
            repeat (3) begin @(negedge clk); if (done) seen++; end
            rst_n = 1'b1;
            repeat (2) begin @(posedge clk); #1; if (done) seen++; end
            check("abort_no_done", 32'(seen), 32'd0);
        end
        for (int k = 0; k < 100; k++)
            px_model($sformatf("abort_cell%0d", k), (20 + k/50)*4, (10 + k%50)*4);
        send("after_abort", 1'b0, 0, 0, 0, 0, 12'h123);
        px_is("after_abort_px", 0, 0, 12'h123);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vga_fb_painter.md
# vga_fb_painter

Cell-based frame buffer with a rectangle-fill engine that feeds the VGA scan driver's pixel-read interface. The scan side presents registered `row`/`col`/`rdn` and samples 12-bit `Din` one clock later. This block answers those reads from a 160x120 cell store, where each cell covers 4x4 screen pixels of a 640x480 frame. A drawing-side command port fills rectangles or clears the screen, writing one cell per clock, independently of scan-out.

## Interface
- `COLS`, 160: cells per line; x coordinate range 0..COLS-1.
- `ROWS`, 120: cell lines; y coordinate range 0..ROWS-1.
- `CELL_SHIFT`, 2: log2 of the cell edge in pixels. Pixel address is shifted right by this amount.
- `clk_25mHz`  in  1  pixel clock. All logic uses its rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `row`  in  9  scan pixel row from the driver.
- `col`  in  10  scan pixel column from the driver.
- `rdn`  in  1  scan read strobe, active low.
- `Din`  out  12  pixel to the driver: {B[11:8], G[7:4], R[3:0]}.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  engine idle and able to accept a command.
- `cmd_clear`  in  1  1 = fill the whole store and ignore the coordinates.
- `cmd_x0`, `cmd_x1`  in  8  inclusive x bounds.
- `cmd_y0`, `cmd_y1`  in  7  inclusive y bounds.
- `cmd_color`  in  12  fill colour.
- `busy`  out  1  engine is in FILL.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Storage is a COLS*ROWS x 12 array with one synchronous read port and one write port.
- Storage contents are not reset. Only control state and outputs are reset.
- Read path:
  - Cell address is cx = `col`>>CELL_SHIFT, cy = `row`>>CELL_SHIFT, index = cy*COLS+cx.
  - `Din` is registered from that index every clock.
  - `Din` is forced to 12'h000 on the next edge if `rdn`=1, `col`>=640 or `row`>=480. The driver's addresses wrap to large values during blanking; these must not alias.
- Command accept: a command is accepted on an edge with `cmd_valid`&&`cmd_ready`. All command fields are latched on that edge.
- Coordinate clamping:
  - `cmd_x1` is clamped to COLS-1 and `cmd_y1` to ROWS-1.
  - If `cmd_x0`>`cmd_x1`(clamped) or `cmd_y0`>`cmd_y1`(clamped), the rectangle is empty. `cmd_x0`/`cmd_y0` at or above the limit also make it empty.
  - `cmd_clear`=1 substitutes bounds (0,0)-(COLS-1,ROWS-1).
- FSM states:
  - IDLE: `cmd_ready`=1. On accept, go to FILL if the rectangle is non-empty, otherwise DONE.
  - FILL: write `cmd_color` to cell (x,y) every clock, starting at (x0,y0).
    - x increments each write. After x==x1, x reloads to x0 and y increments.
    - After writing (x1,y1), go to DONE.
  - DONE: `done`=1 for exactly one cycle, then IDLE.
- Write address arithmetic: index = y*COLS+x, at least 15 bits wide. An incremental running row base is acceptable; no wrap beyond 19199 ever occurs.
- Same-cell read and write on the same edge: the read returns the old value (read-first).
- `cmd_valid` while `cmd_ready`=0 is ignored. The command is not queued.

## Timing
- Reset values: `Din`=0, `cmd_ready`=1, `busy`=0, `done`=0, state IDLE.
- Reset mid-FILL aborts the fill immediately. Cells already written keep the new colour, no `done` is issued, and the engine is in IDLE after release.
- Read latency is 1 clock: `row`/`col`/`rdn` sampled at edge N drive `Din` after edge N.
- Fill timing for a W x H rectangle, with accept at edge E0:
  - Writes occur at edges E1..E(W*H).
  - `busy` is high from E0 through the cycle containing the last write edge.
  - `done` is high in the cycle after E(W*H).
  - `cmd_ready` returns high one cycle after `done`.
- Empty command: no writes, `done` high in the cycle after E1.
- Full clear: 19200 write edges, i.e. 768 us at 25 MHz. Tearing during scan-out is permitted.

## Test plan
- Reset check: hold `rst_n`=0 for 3 clocks, then release -> `Din`=0, `cmd_ready`=1, `busy`=0, `done`=0.
- Clear: clear with colour 12'hF00, then scan `row`=0,`col`=0 with `rdn`=0 -> `Din`=12'hF00 one clock later.
  - Same colour returned at `row`=479,`col`=639.
  - `done` pulses exactly once, 19200 cycles after accept.
- Rectangle: after a clear to 12'h000, fill (2,3)-(4,5) with 12'h0A5.
  - `row`=12,`col`=8 returns 12'h0A5. `row`=12,`col`=7 and `row`=24,`col`=8 return 12'h000.
  - `busy` is high for 9 write cycles.
- Clamping and empty commands:
  - x0=150, x1=255, y0=y1=0 -> exactly 10 cells written (150..159).
  - x0=5, x1=4 -> `done` one cycle after accept, no cells change.
- Blanking: `rdn`=1 -> `Din`=0. Separately, `rdn`=0 with `col`=10'h3F0 (wrapped address) -> `Din`=0.
- Reset mid-fill: assert `rst_n`=0 during a 100-cell fill after 40 writes.
  - Only the first 40 cells hold the new colour.
  - No `done` pulse. A new command is accepted right after release.
